// File: rtl/gaussian_stream_filter.sv
// Streaming Gaussian filter: one 5-pixel window column per beat, reduced by a chain of
// per-column PE stages, with mode-selectable kernel (bypass, 3x3 or 5x5 binomial).
module gaussian_stream_filter #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned ACCUM_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5*PIXEL_WIDTH-1:0] in_col,
    input  logic                     in_sof,
    input  logic                     in_last,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIXEL_WIDTH-1:0]   out_data,
    output logic                     out_sof,
    output logic                     out_last,
    output logic [1:0]               mode_active
);

    localparam int Rows   = 5;
    localparam int Taps   = 5;
    localparam int Stages = 4;

    localparam logic [PIXEL_WIDTH-1:0] PixMax = '1;

    typedef enum logic [1:0] {
        ModeBypass = 2'd0,
        Mode3x3    = 2'd1,
        Mode5x5    = 2'd2,
        ModeRsvd   = 2'd3
    } mode_e;

    function automatic logic [2:0] binom5(input int i);
        logic [2:0] b;
        case (i)
            0, 4:    b = 3'd1;
            1, 3:    b = 3'd4;
            2:       b = 3'd6;
            default: b = 3'd0;
        endcase
        return b;
    endfunction

    // 3-tap binomial padded to 5 taps so the 3x3 kernel sits centred in the 5x5 window.
    function automatic logic [2:0] binom3(input int i);
        logic [2:0] b;
        case (i)
            1, 3:    b = 3'd1;
            2:       b = 3'd2;
            default: b = 3'd0;
        endcase
        return b;
    endfunction

    function automatic logic [5:0] coef(input mode_e m, input int r, input int s);
        logic [5:0] k;
        case (m)
            Mode5x5: k = 6'(binom5(r)) * 6'(binom5(s));
            Mode3x3: k = 6'(binom3(r)) * 6'(binom3(s));
            default: k = (r == 2 && s == 2) ? 6'd1 : 6'd0;
        endcase
        return k;
    endfunction

    // Handshake
    logic  beat;
    mode_e eff_mode;

    logic                   out_valid_q, out_valid_d;
    logic [PIXEL_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_sof_q, out_sof_d;
    logic                   out_last_q, out_last_d;
    logic [1:0]             mode_active_q, mode_active_d;

    assign in_ready = !out_valid_q || out_ready;
    assign beat     = in_valid && in_ready;
    assign eff_mode = mode_e'(in_sof ? mode : mode_active_q);

    // Column counter and first-output tracking
    logic [2:0] col_cnt_q, col_cnt_d;
    logic [2:0] col_j;
    logic       first_pending_q, first_pending_d;
    logic       eff_first;
    logic       emit;

    assign col_j     = in_sof ? 3'd0 : col_cnt_q;
    assign eff_first = in_sof || first_pending_q;
    assign emit      = beat && (col_j == 3'd4);

    always_comb begin
        col_cnt_d       = col_cnt_q;
        first_pending_d = first_pending_q;
        if (beat) begin
            if (in_last) begin
                col_cnt_d = 3'd0;
            end else begin
                col_cnt_d = (col_j == 3'd4) ? 3'd4 : col_j + 3'd1;
            end
            if (emit) begin
                first_pending_d = 1'b0;
            end else if (in_sof) begin
                first_pending_d = 1'b1;
            end
        end
    end

    // Per-coefficient-column weighted sums of the incoming column
    logic [ACCUM_WIDTH-1:0] col_sum [Taps];

    always_comb begin
        for (int s = 0; s < Taps; s++) begin
            col_sum[s] = '0;
            for (int r = 0; r < Rows; r++) begin
                col_sum[s] = col_sum[s]
                           + ACCUM_WIDTH'(coef(eff_mode, r, s))
                           * ACCUM_WIDTH'(in_col[r*PIXEL_WIDTH +: PIXEL_WIDTH]);
            end
        end
    end

    // PE chain: stage s holds the partial sum of the s+1 oldest columns of the window.
    logic [ACCUM_WIDTH-1:0] acc_q [Stages];
    logic [ACCUM_WIDTH-1:0] acc_d [Stages];
    logic [ACCUM_WIDTH-1:0] sum;

    always_comb begin
        for (int s = 0; s < Stages; s++) begin
            acc_d[s] = acc_q[s];
        end
        if (beat) begin
            acc_d[0] = col_sum[0];
            for (int s = 1; s < Stages; s++) begin
                acc_d[s] = acc_q[s-1] + col_sum[s];
            end
        end
    end

    assign sum = acc_q[Stages-1] + col_sum[Taps-1];

    // Round-to-nearest normalisation and clamp
    logic [3:0]             shift;
    logic [ACCUM_WIDTH-1:0] round_add;
    logic [ACCUM_WIDTH-1:0] rounded;
    logic [ACCUM_WIDTH-1:0] shifted;
    logic [PIXEL_WIDTH-1:0] result;

    always_comb begin
        shift     = 4'd0;
        round_add = '0;
        case (eff_mode)
            Mode5x5: begin
                shift     = 4'd8;
                round_add = ACCUM_WIDTH'(128);
            end
            Mode3x3: begin
                shift     = 4'd4;
                round_add = ACCUM_WIDTH'(8);
            end
            default: begin
                shift     = 4'd0;
                round_add = '0;
            end
        endcase
        rounded = sum + round_add;
        shifted = rounded >> shift;
        result  = (shifted > ACCUM_WIDTH'(PixMax)) ? PixMax : shifted[PIXEL_WIDTH-1:0];
    end

    // Output register and mode latch
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sof_d     = out_sof_q;
        out_last_d    = out_last_q;
        mode_active_d = mode_active_q;
        if (beat) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d = result;
                out_sof_d  = eff_first;
                out_last_d = in_last;
            end
            if (in_sof) begin
                mode_active_d = mode;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_sof_q       <= 1'b0;
            out_last_q      <= 1'b0;
            mode_active_q   <= 2'd0;
            col_cnt_q       <= 3'd0;
            first_pending_q <= 1'b0;
            for (int s = 0; s < Stages; s++) begin
                acc_q[s] <= '0;
            end
        end else begin
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_sof_q       <= out_sof_d;
            out_last_q      <= out_last_d;
            mode_active_q   <= mode_active_d;
            col_cnt_q       <= col_cnt_d;
            first_pending_q <= first_pending_d;
            for (int s = 0; s < Stages; s++) begin
                acc_q[s] <= acc_d[s];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sof     = out_sof_q;
    assign out_last    = out_last_q;
    assign mode_active = mode_active_q;

endmodule
